// File: rtl/md_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - ALU function codes decoded by md_unit
//   - FSM state encoding
package md_unit_pkg;

  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_unit_iter_core.sv
// Iterative magnitude datapath shared by multiply and divide.
// One step per cycle; operates on unsigned magnitudes only.
//   Multiply: r_acc = running high half, r_shf = multiplier shifting out
//             (low product bits shift in), r_opd = multiplicand.
//   Divide:   r_acc = partial remainder, r_shf = dividend shifting out
//             (quotient bits shift in), r_opd = divisor.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_load        initialise for a new operation (counter cleared)
//   i_step        perform one iteration
//   i_mode_div    1 = restoring-divide step, 0 = shift-add multiply step
//   i_shf_init    initial shift register value (multiplier / dividend)
//   i_opd_init    fixed operand (multiplicand / divisor)
//   o_last        this step is the final iteration
//   o_acc, o_shf  result halves (product hi/lo or remainder/quotient)
module md_iter_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic                  i_mode_div,
  input  logic [DATA_WIDTH-1:0] i_shf_init,
  input  logic [DATA_WIDTH-1:0] i_opd_init,
  output logic                  o_last,
  output logic [DATA_WIDTH-1:0] o_acc,
  output logic [DATA_WIDTH-1:0] o_shf
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_shf;
  logic [DATA_WIDTH-1:0] r_opd;
  logic [CW-1:0]         r_cnt;

  logic [DATA_WIDTH:0]   w_mul_sum;
  logic [DATA_WIDTH:0]   w_div_shift;
  logic                  w_div_ok;
  logic [DATA_WIDTH-1:0] w_acc_nxt;
  logic [DATA_WIDTH-1:0] w_shf_nxt;

  always_comb begin
    w_acc_nxt   = r_acc;
    w_shf_nxt   = r_shf;
    // Carry out of the add becomes the new top bit after the right shift.
    w_mul_sum   = {1'b0, r_acc} + (r_shf[0] ? {1'b0, r_opd} : '0);
    // Remainder shifted left with the next dividend bit; needs one extra bit.
    w_div_shift = {r_acc, r_shf[DATA_WIDTH-1]};
    w_div_ok    = (w_div_shift >= {1'b0, r_opd});
    if (i_mode_div) begin
      // The restored/subtracted remainder is always < divisor, so W bits suffice.
      w_acc_nxt = w_div_ok ? (w_div_shift[DATA_WIDTH-1:0] - r_opd)
                           : w_div_shift[DATA_WIDTH-1:0];
      w_shf_nxt = {r_shf[DATA_WIDTH-2:0], w_div_ok};
    end else begin
      w_acc_nxt = w_mul_sum[DATA_WIDTH:1];
      w_shf_nxt = {w_mul_sum[0], r_shf[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_shf <= '0;
      r_opd <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_acc <= '0;
      r_shf <= i_shf_init;
      r_opd <= i_opd_init;
      r_cnt <= '0;
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
      r_shf <= w_shf_nxt;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_last = (r_cnt == CW'(DATA_WIDTH - 1));
  assign o_acc  = r_acc;
  assign o_shf  = r_shf;

endmodule

// File: rtl/md_unit.sv
// EX-stage iterative multiply/divide unit with architectural HI/LO.
// MULT/MULTU/DIV/DIVU run for DATA_WIDTH iterations; MTHI/MTLO complete in
// one cycle. The FSM, operand sign handling and HI/LO live here; the
// iteration datapath is md_iter_core.
// Ports:
//   clk            pipeline clock
//   rst            synchronous active-high reset
//   flush          abandon in-flight operation, no HI/LO write
//   en             EX-stage instruction valid for this unit
//   funct          ALU function code
//   operand_1      rs: dividend / multiplicand / MTHI-MTLO source
//   operand_2      rt: divisor / multiplier
//   stall_request  hold IF/ID/EX while an operation is in flight
//   done           one-cycle pulse; HI/LO written at the end of this cycle
//   hi, lo         HI/LO register values
module md_unit
  import md_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  en,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  output logic                  stall_request,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  // Two's-complement magnitude; the most negative value maps onto its
  // unsigned bit pattern, which is the correct magnitude.
  function automatic logic [DATA_WIDTH-1:0] f_mag(input logic signed [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? DATA_WIDTH'(-v) : DATA_WIDTH'(v);
  endfunction

  md_state_e r_state;
  md_state_e w_state_nxt;

  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;
  logic                  r_neg_res;
  logic                  r_neg_rem;
  logic                  r_is_div;
  logic                  r_dz;
  logic [DATA_WIDTH-1:0] r_dz_val;

  logic                  w_is_mul;
  logic                  w_is_div;
  logic                  w_signed;
  logic                  w_issue;
  logic                  w_start;
  logic                  w_dz;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_mag1;
  logic [DATA_WIDTH-1:0] w_mag2;
  logic                  w_core_load;
  logic                  w_core_step;
  logic                  w_core_last;
  logic [DATA_WIDTH-1:0] w_core_acc;
  logic [DATA_WIDTH-1:0] w_core_shf;
  logic [DATA_WIDTH-1:0] w_core_shf_init;
  logic [DATA_WIDTH-1:0] w_core_opd_init;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0] w_quo;
  logic [DATA_WIDTH-1:0] w_rem;
  logic [DATA_WIDTH-1:0] w_res_hi;
  logic [DATA_WIDTH-1:0] w_res_lo;

  // Issue decode
  assign w_is_mul = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  assign w_is_div = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign w_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign w_issue  = (r_state == MD_IDLE) && en && (w_is_mul || w_is_div);
  assign w_start  = w_issue && !flush;
  assign w_dz     = w_is_div && (operand_2 == '0);
  assign w_mag1   = w_signed ? f_mag(operand_1) : operand_1;
  assign w_mag2   = w_signed ? f_mag(operand_2) : operand_2;

  // Multiply shifts the multiplier; divide shifts the dividend.
  assign w_core_shf_init = w_is_div ? w_mag1 : w_mag2;
  assign w_core_opd_init = w_is_div ? w_mag2 : w_mag1;
  assign w_core_load     = w_start && !w_dz;
  assign w_core_step     = (r_state == MD_MUL) || (r_state == MD_DIV);

  md_iter_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_core_load),
    .i_step     (w_core_step),
    .i_mode_div (r_state == MD_DIV),
    .i_shf_init (w_core_shf_init),
    .i_opd_init (w_core_opd_init),
    .o_last     (w_core_last),
    .o_acc      (w_core_acc),
    .o_shf      (w_core_shf)
  );

  // Next state and control outputs
  always_comb begin
    w_state_nxt   = r_state;
    stall_request = 1'b0;
    w_done        = 1'b0;
    if (flush) begin
      w_state_nxt = MD_IDLE;
    end else begin
      unique case (r_state)
        MD_IDLE: begin
          if (w_issue) begin
            stall_request = 1'b1;
            if (w_is_mul)  w_state_nxt = MD_MUL;
            else if (w_dz) w_state_nxt = MD_DONE;
            else           w_state_nxt = MD_DIV;
          end
        end
        MD_MUL, MD_DIV: begin
          stall_request = 1'b1;
          if (w_core_last) w_state_nxt = MD_DONE;
        end
        MD_DONE: begin
          w_done      = 1'b1;
          w_state_nxt = MD_IDLE;
        end
        default: w_state_nxt = MD_IDLE;
      endcase
    end
  end

  // Sign fix-up and result selection
  always_comb begin
    w_prod = {w_core_acc, w_core_shf};
    if (r_neg_res) w_prod = -w_prod;
    w_quo  = r_neg_res ? -w_core_shf : w_core_shf;
    w_rem  = r_neg_rem ? -w_core_acc : w_core_acc;
    if (r_dz) begin
      w_res_hi = r_dz_val;
      w_res_lo = '1;
    end else if (r_is_div) begin
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end else begin
      w_res_hi = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
      w_res_lo = w_prod[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= MD_IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_is_div  <= 1'b0;
      r_dz      <= 1'b0;
      r_dz_val  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_neg_res <= w_signed && (operand_1[DATA_WIDTH-1] ^ operand_2[DATA_WIDTH-1]);
        r_neg_rem <= w_signed && w_is_div && operand_1[DATA_WIDTH-1];
        r_is_div  <= w_is_div;
        r_dz      <= w_dz;
        r_dz_val  <= operand_1;
      end
      if (w_done) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if ((r_state == MD_IDLE) && en && !flush) begin
        if (funct == FUNCT_MTHI) r_hi <= operand_1;
        if (funct == FUNCT_MTLO) r_lo <= operand_1;
      end
    end
  end

  assign done = w_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- EX-stage iterative multiply/divide unit with architectural HI/LO registers.
- Consumes the ALU function code produced in ID, plus both register operands.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle.
- Raises a stall request to the pipeline controller while an operation is in flight.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- flush  in  1  abandon in-flight operation (exception/redirect)
- en  in  1  EX-stage instruction valid for this unit
- funct  in  6  ALU function code from ID
- operand_1  in  DATA_WIDTH  rs value; dividend / multiplicand / MTHI-MTLO source
- operand_2  in  DATA_WIDTH  rt value; divisor / multiplier
- stall_request  out  1  hold IF/ID/EX stages
- done  out  1  one-cycle pulse; HI/LO updated at this clock edge
- hi  out  DATA_WIDTH  current HI register
- lo  out  DATA_WIDTH  current LO register

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; hi=0, lo=0, done=0, stall_request=0; counter and datapath registers cleared.
- States:
  - IDLE: waiting for an issue.
  - MUL: shift-add, one multiplier bit per cycle.
  - DIV: restoring division, one quotient bit per cycle.
  - DONE: sign fix-up and HI/LO write.
- Start condition: en=1 in IDLE, with funct one of MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- On start:
  - Latch magnitudes of the operands (two's-complement absolute value for signed ops; 0x80000000 maps to unsigned 0x80000000).
  - Latch the result-sign and remainder-sign flags.
  - Set counter=0 and go to MUL or DIV.
- Divisor zero on DIV/DIVU: skip DIV and go straight to DONE. Write lo=all-ones, hi=operand_1.
- MUL/DIV: one iteration per cycle. After DATA_WIDTH iterations (counter reaches DATA_WIDTH-1), go to DONE.
- DONE:
  - Write {hi,lo} = 64-bit product, negated if MULT and the operand signs differ.
  - For division: lo=quotient, negated if the signs differ; hi=remainder, taking the sign of the dividend.
  - done=1 for this cycle; next state IDLE.
- stall_request (combinational):
  - 1 in IDLE when the start condition holds.
  - 1 in MUL and DIV.
  - 0 in DONE, so the instruction advances in the cycle it retires.
- Timing:
  - Multiply or non-zero divide: stall for exactly DATA_WIDTH+1 cycles (issue cycle + iterations); HI/LO visible the cycle after done.
  - Divide by zero: stall for 1 cycle.
- MTHI (010001) / MTLO (010011) with en=1 in IDLE: write hi or lo from operand_1 at the next edge. No stall, no done.
- en and funct are ignored outside IDLE; the pipeline is stalled, so inputs are held.
- Any other funct value: no action.
- flush=1 in any state (including DONE or the IDLE start cycle):
  - Next state IDLE; HI/LO not written; done=0.
  - stall_request is forced 0 in that cycle. flush has priority over start.
- rst has priority over flush.
- hi/lo are plain register outputs. MFHI/MFLO forwarding is the consumer's responsibility.

Decomposition:
- Add FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO to funct.v.
- Add `MD_STATE_BUS` and the state encodings to bus.v.
- Sub-module md_iter_core: holds the accumulator/partial-remainder, shift registers and counter. One step per cycle for either mul or div (mode input); magnitude in, magnitude out.
- md_unit owns the FSM, the sign handling and HI/LO.

Test Plan:
- MULT -3 × 5 → stall_request high 33 cycles, done pulse, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, same latency.
- DIVU 100/7 → lo=14, hi=2. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/-1 → lo=0x80000000, hi=0.
- DIV 5/0 → stall 1 cycle, done next cycle, lo=0xFFFFFFFF, hi=5.
- Start MULT with hi=0x11 and lo=0x22, assert flush at iteration 10 → IDLE next cycle, stall_request 0 in the flush cycle, no done, hi=0x11, lo=0x22 unchanged. Also flush exactly in the DONE cycle → no write.
- MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A back-to-back → no stall, hi/lo updated each next edge. rst asserted mid-DIV → hi=lo=0, state IDLE, stall_request 0.
